// File: rtl/neurocore_pkg.sv
// Shared definitions for the neural-core configuration controller.
//   SYNC_BYTE       : packet start marker
//   OP_*            : command opcodes carried in CMD[7:6]
//   state_e         : packet FSM state encoding
//   LOG_*           : bit positions inside the 8-bit logs status bus
package neurocore_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD      = 3'd1,
    ST_LEN      = 3'd2,
    ST_DATA     = 3'd3,
    ST_CSUM     = 3'd4,
    ST_COMMIT   = 3'd5,
    ST_RUN_WAIT = 3'd6
  } state_e;

  localparam int LOG_BUSY    = 0;
  localparam int LOG_CSUM    = 1;
  localparam int LOG_LEN     = 2;
  localparam int LOG_FRAME   = 3;
  localparam int LOG_CNT_LSB = 4;
  localparam int LOG_CNT_MSB = 7;

endpackage

// File: rtl/nc_payload_buf.sv
// Payload staging buffer: MAX_LEN x 8-bit register array.
// Holds WRITE payload bytes until the packet checksum is verified.
//   clk_i    : clock
//   we_i     : write enable (DATA state)
//   waddr_i  : write index
//   wdata_i  : write byte
//   raddr_i  : read index (COMMIT state)
//   rdata_o  : combinational read data
// Contents are not reset: a byte is always written before it is read.
module nc_payload_buf #(
  parameter int MAX_LEN = 8,
  parameter int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [MAX_LEN];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/nc_cfg_controller.sv
// Packet-level command controller between the UART byte receiver and the
// neural core. Parses SYNC/CMD/[LEN]/[DATA]/CSUM packets, stages WRITE
// payload until the checksum matches, then commits one byte per cycle to
// the config memory; RUN packets raise a one-cycle start once the core
// is idle.
//   CLK, RESET          : clock, asynchronous active-high reset
//   rx_valid/rx_data    : received byte strobe and byte
//   rx_err              : framing error, qualified by rx_valid
//   core_busy           : core running, holds off start
//   wr_en/wr_addr/wr_data : config memory write port
//   start               : one-cycle core start pulse
//   logs                : {good_cnt[3:0], frame_err, len_err, csum_err, busy}
// Optional build macro NC_CFG_TIMEOUT_EN: adds the inter-byte timeout
// counter that aborts a stalled packet with frame_err.
module nc_cfg_controller
  import neurocore_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int MAX_LEN = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_err,
  input  logic              core_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              start,
  output logic [7:0]        logs
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  if (MAX_LEN < 1 || MAX_LEN > 16 || TIMEOUT < 1) begin : g_bad_param
    $error("nc_cfg_controller: MAX_LEN must be 1..16 and TIMEOUT >= 1");
  end

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;      // base address, then running commit address
  logic [4:0]        len_q, len_d;
  logic [4:0]        idx_q, idx_d;        // payload index for DATA and COMMIT
  logic [7:0]        csum_q, csum_d;
  logic              csum_err_q, csum_err_d;
  logic              len_err_q, len_err_d;
  logic              frame_err_q, frame_err_d;
  logic [3:0]        good_cnt_q, good_cnt_d;

  logic              buf_we;
  logic [7:0]        buf_rdata;
  logic              byte_ok;
  logic              in_parse;
  logic              good;
  logic              commit_last;

`ifdef NC_CFG_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0]  tmo_q, tmo_d;
`endif

  nc_payload_buf #(
    .MAX_LEN (MAX_LEN),
    .IDX_W   (IDX_W)
  ) u_buf (
    .clk_i   (CLK),
    .we_i    (buf_we),
    .waddr_i (idx_q[IDX_W-1:0]),
    .wdata_i (rx_data),
    .raddr_i (idx_q[IDX_W-1:0]),
    .rdata_o (buf_rdata)
  );

  assign byte_ok  = rx_valid && !rx_err;
  assign in_parse = (state_q == ST_IDLE) || (state_q == ST_CMD) || (state_q == ST_LEN) ||
                    (state_q == ST_DATA) || (state_q == ST_CSUM);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    len_d       = len_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    csum_err_d  = csum_err_q;
    len_err_d   = len_err_q;
    frame_err_d = frame_err_q;
    good_cnt_d  = good_cnt_q;
    buf_we      = 1'b0;
    wr_en       = 1'b0;
    start       = 1'b0;
    good        = 1'b0;
    commit_last = 1'b0;
`ifdef NC_CFG_TIMEOUT_EN
    tmo_d       = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (byte_ok && rx_data == SYNC_BYTE) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (byte_ok) begin
          op_d   = rx_data[7:6];
          addr_d = rx_data[ADDR_W-1:0];
          csum_d = rx_data;               // checksum restarts at the first byte after SYNC
          case (rx_data[7:6])
            OP_WRITE: state_d = ST_LEN;
            OP_RUN,
            OP_CLEAR: state_d = ST_CSUM;
            default: begin
              len_err_d = 1'b1;
              state_d   = ST_IDLE;
            end
          endcase
        end
      end
      ST_LEN: begin
        if (byte_ok) begin
          csum_d = csum_q ^ rx_data;
          if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
            len_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            len_d   = rx_data[4:0];
            idx_d   = '0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (byte_ok) begin
          buf_we = 1'b1;
          csum_d = csum_q ^ rx_data;
          idx_d  = idx_q + 5'd1;
          if (idx_q == len_q - 5'd1) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (byte_ok) begin
          if (rx_data != csum_q) begin
            csum_err_d = 1'b1;
            state_d    = ST_IDLE;
          end else if (op_q == OP_RUN) begin
            state_d = ST_RUN_WAIT;
          end else begin
            idx_d = '0;
            if (op_q == OP_CLEAR) addr_d = '0;
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        wr_en  = 1'b1;
        addr_d = addr_q + 1'b1;
        idx_d  = idx_q + 5'd1;
        if (op_q == OP_WRITE) commit_last = (idx_q == len_q - 5'd1);
        else                  commit_last = (addr_q == '1);
        if (commit_last) begin
          good    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RUN_WAIT: begin
        if (!core_busy) begin
          start   = 1'b1;
          good    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A completed packet clears the sticky flags; any error raised in the
    // same cycle is applied afterwards so it is not lost.
    if (good) begin
      csum_err_d  = 1'b0;
      len_err_d   = 1'b0;
      frame_err_d = 1'b0;
      good_cnt_d  = good_cnt_q + 4'd1;
    end

    // Verified work is never abandoned: bytes arriving during COMMIT or
    // RUN_WAIT (errored or not) are dropped and only flagged.
    if (rx_valid && !in_parse) frame_err_d = 1'b1;

    if (rx_valid && rx_err && in_parse) begin
      frame_err_d = 1'b1;
      state_d     = ST_IDLE;
    end

`ifdef NC_CFG_TIMEOUT_EN
    // Counts idle cycles inside a packet; any byte reloads it.
    if (in_parse && state_q != ST_IDLE && !rx_valid) begin
      if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
        frame_err_d = 1'b1;
        state_d     = ST_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_WRITE;
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      csum_err_q  <= 1'b0;
      len_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      good_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      csum_err_q  <= csum_err_d;
      len_err_q   <= len_err_d;
      frame_err_q <= frame_err_d;
      good_cnt_q  <= good_cnt_d;
    end
  end

`ifdef NC_CFG_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

  assign wr_addr = addr_q;
  assign wr_data = (state_q == ST_COMMIT && op_q == OP_WRITE) ? buf_rdata : 8'h00;

  always_comb begin
    logs                          = '0;
    logs[LOG_BUSY]                = (state_q != ST_IDLE);
    logs[LOG_CSUM]                = csum_err_q;
    logs[LOG_LEN]                 = len_err_q;
    logs[LOG_FRAME]               = frame_err_q;
    logs[LOG_CNT_MSB:LOG_CNT_LSB] = good_cnt_q;
  end

endmodule

// File: tb/tb_nc_cfg_controller.sv
// Directed testbench for nc_cfg_controller.
module tb_nc_cfg_controller;

  localparam int ADDR_W  = 6;
  localparam int MAX_LEN = 8;
  localparam int TIMEOUT = 1024;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_err;
  logic              core_busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              start;
  logic [7:0]        logs;

  int n_checks = 0;
  int n_pass   = 0;

  logic [13:0] exp_q[$];   // {addr, data} of each expected write
  logic [7:0]  pkt[$];

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  nc_cfg_controller #(
    .ADDR_W  (ADDR_W),
    .MAX_LEN (MAX_LEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_err    (rx_err),
    .core_busy (core_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .logs      (logs)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: every write strobe must match the head of exp_q.
  always @(negedge CLK) begin
    if (!RESET && wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", {18'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
      end else begin
        check("wr_addr_data", {18'd0, wr_addr, wr_data}, {18'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the last byte is taken.
  task automatic send_pkt();
    foreach (pkt[i]) begin
      rx_valid = 1'b1;
      rx_data  = pkt[i];
      @(negedge CLK);
    end
    rx_valid = 1'b0;
  endtask

  task automatic push_wr(input int addr, input int data);
    exp_q.push_back({6'(addr), 8'(data)});
  endtask

  task automatic expect_burst(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check(tag, wr_en, 1);
      @(negedge CLK);
    end
    check(tag, wr_en, 0);
  endtask

  task automatic expect_no_wr(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check(tag, wr_en, 0);
      @(negedge CLK);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RESET = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_err = 1'b0; core_busy = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_wr_en", wr_en, 0);
    check("rst_start", start, 0);
    check("rst_logs",  logs,  8'h00);
    RESET = 1'b0;
    @(negedge CLK);

    // Write of two bytes at base 5.
    pkt = '{8'hA5, 8'h05, 8'h02, 8'h11, 8'h22, 8'h34};
    push_wr(5, 8'h11); push_wr(6, 8'h22);
    send_pkt();
    expect_burst("write_en", 2);
    check("write_logs", logs, 8'h10);

    // Address wrap 63 -> 0; csum 3F^02^AA^BB = 2C.
    pkt = '{8'hA5, 8'h3F, 8'h02, 8'hAA, 8'hBB, 8'h2C};
    push_wr(63, 8'hAA); push_wr(0, 8'hBB);
    send_pkt();
    expect_burst("wrap_en", 2);
    check("wrap_logs", logs, 8'h20);

    // Bad checksum: no writes, csum_err raised.
    pkt = '{8'hA5, 8'h05, 8'h02, 8'h11, 8'h22, 8'h35};
    send_pkt();
    expect_no_wr("badcsum_no_wr", 3);
    check("badcsum_logs", logs, 8'h22);

    // Recovery packet clears the flag: csum 05^01^77 = 73.
    pkt = '{8'hA5, 8'h05, 8'h01, 8'h77, 8'h73};
    push_wr(5, 8'h77);
    send_pkt();
    expect_burst("recover_en", 1);
    check("recover_logs", logs, 8'h30);

    // RUN held off by core_busy.
    pkt = '{8'hA5, 8'h40};
    send_pkt();
    core_busy = 1'b1;
    pkt = '{8'h40};
    send_pkt();
    for (int i = 0; i < 10; i++) begin
      check("run_hold_start", start, 0);
      check("run_hold_busy", logs[0], 1);
      @(negedge CLK);
    end
    core_busy = 1'b0;
    #1;
    check("run_start_pulse", start, 1);
    @(negedge CLK);
    check("run_start_single", start, 0);
    check("run_logs", logs, 8'h40);

    // LEN = 0.
    pkt = '{8'hA5, 8'h00, 8'h00};
    send_pkt();
    check("len0_logs", logs, 8'h44);
    pkt = '{8'hA5, 8'h01, 8'h01, 8'h5A, 8'h5A};
    push_wr(1, 8'h5A);
    send_pkt();
    expect_burst("after_len0_en", 1);
    check("after_len0_logs", logs, 8'h50);

    // LEN = MAX_LEN + 1.
    pkt = '{8'hA5, 8'h00, 8'h09};
    send_pkt();
    check("len9_logs", logs, 8'h54);

    // LEN = MAX_LEN, bytes 1..8 at base 2; csum 02^08^08 = 02.
    pkt = '{8'hA5, 8'h02, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h02};
    for (int i = 0; i < 8; i++) push_wr(2 + i, i + 1);
    send_pkt();
    expect_burst("maxlen_en", 8);
    check("maxlen_logs", logs, 8'h60);

    // Reserved opcode.
    pkt = '{8'hA5, 8'hC0};
    send_pkt();
    check("rsvd_logs", logs, 8'h64);

    // Framing error inside a packet.
    pkt = '{8'hA5};
    send_pkt();
    rx_valid = 1'b1; rx_err = 1'b1; rx_data = 8'h12;
    @(negedge CLK);
    rx_valid = 1'b0; rx_err = 1'b0;
    check("rxerr_logs", logs, 8'h6C);

    // RUN with the core idle: start on the first cycle in RUN_WAIT.
    pkt = '{8'hA5, 8'h40, 8'h40};
    send_pkt();
    check("run2_start", start, 1);
    @(negedge CLK);
    check("run2_logs", logs, 8'h70);

    // CLEAR with a stray byte mid-commit.
    pkt = '{8'hA5, 8'h80, 8'h80};
    for (int i = 0; i < 64; i++) push_wr(i, 0);
    send_pkt();
    for (int i = 0; i < 64; i++) begin
      check("clear_en", wr_en, 1);
      if (i == 11) begin
        rx_valid = 1'b0;
        check("clear_overrun_flag", logs[3], 1);
      end
      if (i == 10) begin
        rx_valid = 1'b1; rx_data = 8'h55;
      end
      @(negedge CLK);
    end
    check("clear_end", wr_en, 0);
    check("clear_logs", logs, 8'h80);

    // Stall after A5,05.
    pkt = '{8'hA5, 8'h05};
    send_pkt();
`ifdef NC_CFG_TIMEOUT_EN
    repeat (TIMEOUT - 1) @(negedge CLK);
    check("tmo_still_busy", logs[0], 1);
    @(negedge CLK);
    check("tmo_logs", logs, 8'h88);
    pkt = '{8'hA5, 8'h05, 8'h01, 8'h77, 8'h73};
`else
    repeat (TIMEOUT + 76) @(negedge CLK);
    check("stall_still_busy", logs, 8'h81);
    pkt = '{8'h01, 8'h77, 8'h73};
`endif
    push_wr(5, 8'h77);
    send_pkt();
    expect_burst("post_stall_en", 1);
    check("post_stall_logs", logs, 8'h90);

    // Async reset in the middle of a CLEAR.
    pkt = '{8'hA5, 8'h80, 8'h80};
    for (int i = 0; i < 64; i++) push_wr(i, 0);
    send_pkt();
    for (int i = 0; i < 5; i++) begin
      check("rstmid_en", wr_en, 1);
      @(negedge CLK);
    end
    #3;
    RESET = 1'b1;
    exp_q.delete();
    #1;
    check("rstmid_wr_en", wr_en, 0);
    check("rstmid_start", start, 0);
    check("rstmid_logs", logs, 8'h00);
    @(negedge CLK);
    RESET = 1'b0;
    expect_no_wr("rstmid_after", 4);
    check("rstmid_logs_after", logs, 8'h00);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nc_cfg_controller.md
Name: nc_cfg_controller

Overview:
- Packet-level command controller between the UART byte receiver and the neural core.
- Parses framed command packets from received bytes and buffers the write payload until its checksum is verified.
- Commits verified payload bytes to the core weight/config memory at one write per cycle, and sequences core start requests.
- Drives the 8-bit `logs` status bus to the pads.

Parameters:
- ADDR_W, 6, config memory address width; addresses wrap modulo 2^ADDR_W.
- MAX_LEN, 8, maximum payload bytes per WRITE packet (1..16).
- TIMEOUT, 1024, idle cycles allowed between bytes inside a packet.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-high reset.
- rx_valid  input  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  input  8  received byte.
- rx_err  input  1  framing error, qualified by rx_valid.
- core_busy  input  1  core is running; start is held off while high.
- wr_en  output  1  config memory write strobe.
- wr_addr  output  ADDR_W  write address.
- wr_data  output  8  write data.
- start  output  1  one-cycle core start pulse.
- logs  output  8  status: [0] busy (state != IDLE), [1] csum_err, [2] len_err, [3] frame_err, [7:4] good-packet count mod 16.

Behaviour:
- Reset (async): state=IDLE; all outputs 0; error flags 0; counter 0.
- Packet format: SYNC 0xA5, CMD, [LEN], [LEN data bytes], CSUM.
  - CMD[7:6] is the opcode: 00 WRITE, 01 RUN, 10 CLEAR, 11 reserved.
  - CMD[ADDR_W-1:0] is the base address for WRITE.
- CSUM is the XOR of every byte after SYNC. LEN is present only for WRITE.
- States:
  - IDLE: bytes other than 0xA5 are discarded silently; 0xA5 -> CMD.
  - CMD: opcode 00 -> LEN. Opcode 01/10 -> CSUM. Opcode 11 -> len_err, then IDLE.
  - LEN: LEN=0 or LEN>MAX_LEN -> len_err, then IDLE. Otherwise -> DATA.
  - DATA: store the byte at buffer index i; after the LEN-th byte -> CSUM.
  - CSUM: mismatch -> csum_err, then IDLE, with no writes and no start. Match -> COMMIT (WRITE/CLEAR) or RUN_WAIT (RUN).
  - COMMIT:
    - wr_en is high for consecutive cycles, starting the cycle after the CSUM byte is accepted.
    - WRITE: wr_addr = base+k (wraps), wr_data = buf[k], k=0..LEN-1.
    - CLEAR: wr_data = 0 for addresses 0..2^ADDR_W-1.
    - Exit to IDLE.
  - RUN_WAIT: start pulses for one cycle on the first cycle with core_busy=0, then IDLE.
- A packet counts as good when COMMIT ends or start pulses; logs[7:4] increments then and wraps 15->0.
- The error flags (logs[3:1]) are sticky; all three clear when a good packet completes.
- rx_valid with rx_err in any state: discard the byte, set frame_err, go to IDLE.
- rx_valid during COMMIT/RUN_WAIT: drop the byte, set frame_err, continue the current state.
- Timeout: in CMD, LEN, DATA and CSUM, TIMEOUT cycles without rx_valid -> frame_err, then IDLE. The counter reloads on every accepted byte.
- RESET mid-COMMIT aborts immediately. Writes already issued stand; the remaining writes are lost.

Optional Feature:
- NC_CFG_TIMEOUT_EN defined: the timeout counter and its abort path are built as described.
- Undefined: no counter. The packet FSM waits indefinitely for the next byte; frame_err comes from rx_err and overrun only.

Decomposition:
- Package neurocore_pkg holds:
  - SYNC_BYTE=8'hA5.
  - Opcode constants OP_WRITE/OP_RUN/OP_CLEAR/OP_RSVD.
  - The state enum.
  - The logs bit-index constants.
- One sub-module, nc_payload_buf: a MAX_LEN x 8 register array with a write port (DATA) and an indexed read port (COMMIT).
- Parser FSM, checksum, counters and status stay in the top.

Test Plan:
- Write with wrap:
  - Stimulus: A5,05,02,11,22,34.
  - Required: wr_en on 2 consecutive cycles, (5,0x11) then (6,0x22); logs[7:4]=1; logs[3:1]=0.
  - Wrap variant: A5,3F,02,AA,BB,CSUM → writes to 63 then 0.
- Bad checksum: A5,05,02,11,22,35 → no wr_en; logs[1]=1; a following valid packet clears it and bumps the count.
- Run:
  - Stimulus: A5,40,40 with core_busy=1 for 10 cycles.
  - Required: start stays 0 while core_busy=1; start is a single pulse the first cycle core_busy=0; logs[0] is 1 until then.
- Length limits: LEN=0 and LEN=MAX_LEN+1 → logs[2]=1, FSM back in IDLE; the next A5 packet is parsed correctly.
- Clear: A5,80,80 → 64 consecutive zero writes, addr 0..63; a byte sent mid-COMMIT sets logs[3] without breaking the sequence.
- Errors and reset:
  - Timeout (NC_CFG_TIMEOUT_EN): stall after A5,05 for TIMEOUT cycles → logs[3]=1, state IDLE.
  - Async RESET mid-COMMIT: outputs 0 immediately.
